apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  - APB3 bridge between the CPU-side request port and the APB slave peripherals (UART, GPIO, ...).
//  - Decodes the address, drives PSEL/PENABLE through the SETUP/ACCESS phases and waits on the selected slave's PREADY.
//  - Muxes that slave's PRDATA back and returns a one-cycle response with an error flag.
//  - Error is flagged for an unmapped address or a PREADY timeout.
// PARAMETERS
//  NUM_SLAVES  4             number of APB slaves (1..16); slave i owns 0x1000_i000..0x1000_iFFF
//  BASE_ADDR   32'h1000_0000 APB region base; only bits [31:16] are compared
//  TIMEOUT     16            max ACCESS cycles waiting on PREADY; 0 = wait forever
// PORTS
//  PCLK        in   1            clock, all logic on posedge
//  PRESET      in   1            synchronous reset, active-low
//  req_valid   in   1            CPU transfer request
//  req_write   in   1            1 = write, 0 = read
//  req_addr    in   32           byte address
//  req_wdata   in   32           write data
//  req_ready   out  1            request accepted when req_valid && req_ready
//  rsp_valid   out  1            one-cycle completion pulse
//  rsp_rdata   out  32           read data, valid with rsp_valid (0 for writes/errors)
//  rsp_err     out  1            1 = unmapped address or timeout, valid with rsp_valid
//  PADDR       out  32           latched req_addr; slaves use the low bits
//  PWDATA      out  32           latched req_wdata
//  PWRITE      out  1            latched req_write
//  PENABLE     out  1            high in ACCESS phase
//  PSEL        out  NUM_SLAVES   one-hot slave select
//  PRDATA_S    in   NUM_SLAVES x 32  per-slave read data
//  PREADY_S    in   NUM_SLAVES   per-slave ready
// BEHAVIOUR
//  - Reset (PRESET==0 at posedge):
//    - state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
//    - rsp_valid=0, rsp_err=0, rsp_rdata=0, timeout counter=0.
//  - Reset mid-transfer aborts it: no rsp_valid is produced, and PSEL/PENABLE are low from the next edge.
//  - req_ready = (state==IDLE), combinational.
//  - Decode:
//    - Hit when addr[31:16]==BASE_ADDR[31:16] and addr[15:12] < NUM_SLAVES.
//    - Slave index is addr[15:12].
//  - FSM states:
//    - IDLE: accept the request and latch addr/wdata/write/index into PADDR/PWDATA/PWRITE. Hit -> SETUP; miss -> ERR.
//    - SETUP (1 cycle): PSEL[idx]=1, PENABLE=0 -> ACCESS.
//    - ACCESS: PSEL[idx]=1, PENABLE=1.
//      - PREADY_S[idx]==1 -> IDLE; register rsp_valid=1, rsp_err=0, rsp_rdata = read ? PRDATA_S[idx] : 0.
//      - Else the counter increments. When it reaches TIMEOUT (TIMEOUT!=0) -> IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0.
//    - ERR (1 cycle): PSEL=0 -> IDLE; register rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  - Latency: request accepted at edge k; SETUP cycle k+1, ACCESS from k+2; zero-wait slave gives rsp_valid in cycle k+3.
//  - Each PREADY wait cycle adds 1. Unmapped access gives rsp_valid in cycle k+2.
//  - rsp_valid is high for exactly one cycle. req_ready is already high in that same cycle, so back-to-back accept is allowed.
//  - PADDR/PWDATA/PWRITE are stable from SETUP through the end of ACCESS.
//  - PREADY_S/PRDATA_S of non-selected slaves are ignored.
//  - Timeout counter is cleared on entry to SETUP. Width is $clog2(TIMEOUT+1); no wrap.
//  - PREADY arriving in the same cycle the counter hits TIMEOUT counts as success (PREADY wins).
//  - req_valid while not IDLE is ignored; the requester holds it until req_ready.
// STRUCTURE
//  - apb_pkg:
//    - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} apb_state_e
//    - localparam APB_AW=32, APB_DW=32
//    - slave region size 4 KB
//  - One sub-module, apb_addr_decoder (combinational): addr -> hit, idx, one-hot sel.
//  - FSM, response registers and timeout counter live in apb_master.
// TESTING
//  1. Write 0x1000_0000 <- 0x0000_00A5, PREADY_S=1 -> PSEL=0001 cycles k+1..k+2, PENABLE only k+2, PWDATA=0xA5; rsp_valid at k+3, err=0.
//  2. Read 0x1000_1004, PREADY_S[1] low 3 ACCESS cycles, PRDATA_S[1]=0x5A -> PSEL=0010 held 5 cycles; rsp_rdata=0x5A at k+6, err=0.
//  3. Read 0x2000_0000 and 0x1000_5000 (NUM_SLAVES=4) -> PSEL stays 0; rsp_valid at k+2 with rsp_err=1, rsp_rdata=0.
//  4. TIMEOUT=16, PREADY_S[2] stuck 0 -> PSEL/PENABLE drop after 16 ACCESS cycles; rsp_err=1. Next request accepted same cycle.
//  5. PRESET=0 during ACCESS -> next edge PSEL=0, PENABLE=0, rsp_valid never pulses; req_ready=1 after release.
//  6. Back-to-back writes to slave 0 with req_valid held: second accepted in first's rsp_valid cycle; PADDR updates only at second SETUP.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_pkg                                                              |
// | Shared types and constants for the APB3 master bridge.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package apb_pkg;

    localparam int APB_AW             = 32;
    localparam int APB_DW             = 32;
    localparam int SLAVE_REGION_BYTES = 4096;
    localparam int SLAVE_IDX_LSB      = $clog2(SLAVE_REGION_BYTES);
    localparam int SLAVE_IDX_W        = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_e;

    // A zero timeout still needs a 1-bit counter so the datapath has a legal width.
    function automatic int cnt_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_if                                                        |
// | CPU request/response port plus APB3 bus towards the slaves.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface apb_master_if #(
    parameter int NUM_SLAVES = 4
);
    import apb_pkg::*;

    logic                              req_valid;
    logic                              req_write;
    logic [APB_AW-1:0]                 req_addr;
    logic [APB_DW-1:0]                 req_wdata;
    logic                              req_ready;
    logic                              rsp_valid;
    logic [APB_DW-1:0]                 rsp_rdata;
    logic                              rsp_err;

    logic [APB_AW-1:0]                 PADDR;
    logic [APB_DW-1:0]                 PWDATA;
    logic                              PWRITE;
    logic                              PENABLE;
    logic [NUM_SLAVES-1:0]             PSEL;
    logic [NUM_SLAVES-1:0][APB_DW-1:0] PRDATA_S;
    logic [NUM_SLAVES-1:0]             PREADY_S;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA_S, PREADY_S,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA_S, PREADY_S,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL
    );

endinterface
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_addr_decoder                                                     |
// | Maps a byte address onto a 4 KB slave window: hit, index, one-hot.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic [APB_AW-1:0]      addr,
    output logic                   hit,
    output logic [SLAVE_IDX_W-1:0] idx,
    output logic [NUM_SLAVES-1:0]  sel
);

    logic w_base_match;
    logic w_idx_in_range;
    logic w_unused_offset;

    assign idx             = addr[SLAVE_IDX_LSB +: SLAVE_IDX_W];
    assign w_base_match    = (addr[APB_AW-1:16] == BASE_ADDR[APB_AW-1:16]);
    // Extra bit lets NUM_SLAVES == 16 compare without overflow.
    assign w_idx_in_range  = ({1'b0, idx} < (SLAVE_IDX_W+1)'(NUM_SLAVES));
    assign hit             = w_base_match && w_idx_in_range;
    assign w_unused_offset = ^addr[SLAVE_IDX_LSB-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel[gi] = hit && (idx == SLAVE_IDX_W'(gi));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master                                                           |
// | APB3 bridge: CPU request -> SETUP/ACCESS on one slave -> response.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apb_master
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                TIMEOUT    = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);

    localparam int               CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W:0]   C_TIMEOUT = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W:0]   C_ONE     = (CNT_W+1)'(1);

    apb_state_e                 r_state;
    apb_state_e                 w_next_state;
    logic [NUM_SLAVES-1:0]      r_sel;
    logic [CNT_W-1:0]           r_cnt;

    logic                       w_dec_hit;
    logic [SLAVE_IDX_W-1:0]     w_unused_dec_idx;
    logic [NUM_SLAVES-1:0]      w_dec_sel;
    logic                       w_accept;
    logic                       w_pready;
    logic [APB_DW-1:0]          w_prdata;
    logic [CNT_W:0]             w_cnt_inc;
    logic                       w_timeout;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decoder (
        .addr (bus.req_addr),
        .hit  (w_dec_hit),
        .idx  (w_unused_dec_idx),
        .sel  (w_dec_sel)
    );

    assign w_accept  = (r_state == IDLE) && bus.req_valid;
    assign w_pready  = |(bus.PREADY_S & r_sel);
    assign w_cnt_inc = {1'b0, r_cnt} + C_ONE;
    // Fires on the ACCESS cycle whose non-ready edge would bring the count to TIMEOUT.
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == C_TIMEOUT);

    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) begin
                w_prdata = w_prdata | bus.PRDATA_S[i];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_next_state = w_dec_hit ? SETUP : ERR;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                if (w_pready || w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            ERR: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = (r_state == IDLE);
        bus.PSEL      = '0;
        bus.PENABLE   = 1'b0;
        case (r_state)
            SETUP: begin
                bus.PSEL = r_sel;
            end
            ACCESS: begin
                bus.PSEL    = r_sel;
                bus.PENABLE = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Address phase registers change only on acceptance, so they stay stable through ACCESS.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            bus.PADDR  <= '0;
            bus.PWDATA <= '0;
            bus.PWRITE <= 1'b0;
            r_sel      <= '0;
        end else if (w_accept) begin
            bus.PADDR  <= bus.req_addr;
            bus.PWDATA <= bus.req_wdata;
            bus.PWRITE <= bus.req_write;
            r_sel      <= w_dec_sel;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == ACCESS) && !w_pready && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            case (r_state)
                ACCESS: begin
                    if (w_pready) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= bus.PWRITE ? '0 : w_prdata;
                    end else if (w_timeout) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end
                end
                ERR: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_master                                                        |
// | Vector table, random transfers against a transaction model, corners. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_apb_master;
    import apb_pkg::*;

    localparam int NS  = 4;
    localparam int TMO = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    int   total = 0;
    int   bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_master_if #(.NUM_SLAVES(NS)) bus ();

    apb_master #(
        .NUM_SLAVES (NS),
        .BASE_ADDR  (32'h1000_0000),
        .TIMEOUT    (TMO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] sdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Whole-transaction view: outcome and cycles from acceptance to the response pulse.
    function automatic void model(input logic wr, input logic [31:0] addr, input int waits,
                                  input logic [31:0] sdata, output logic err,
                                  output logic [31:0] rdata, output int lat);
        bit hit;
        hit = (addr[31:16] == 16'h1000) && (int'(addr[15:12]) < NS);
        if (!hit) begin
            err = 1'b1; rdata = '0; lat = 2;
        end else if (waits >= TMO) begin
            err = 1'b1; rdata = '0; lat = 2 + TMO;
        end else begin
            err = 1'b0; rdata = wr ? 32'h0 : sdata; lat = 3 + waits;
        end
    endfunction

    task automatic drive_slaves(input bit hit, input int idx, input logic rdy, input logic [31:0] sdata);
        for (int i = 0; i < NS; i++) begin
            bus.PREADY_S[i] = 1'($urandom);
            bus.PRDATA_S[i] = $urandom;
        end
        if (hit) begin
            bus.PREADY_S[idx] = rdy;
            bus.PRDATA_S[idx] = sdata;
        end
    endtask

    // Called at a negedge with the bridge idle; returns at the negedge of the response.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] sdata,
                        input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        bit              hit;
        int              idx;
        logic [NS-1:0]   onehot;
        bit              proto_ok = 1'b1;
        int              lat = 0;
        logic            got_err = 1'bx;
        logic [31:0]     got_rdata = 'x;
        logic            got_ready = 1'bx;
        hit    = (addr[31:16] == 16'h1000) && (int'(addr[15:12]) < NS);
        idx    = int'(addr[15:12]);
        onehot = '0;
        if (hit) onehot[idx] = 1'b1;

        check({tag, " ready_before"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        drive_slaves(hit, idx, 1'b0, sdata);
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                lat       = c;
                got_err   = bus.rsp_err;
                got_rdata = bus.rsp_rdata;
                got_ready = bus.req_ready;
                if (bus.PSEL != '0 || bus.PENABLE) proto_ok = 1'b0;
                break;
            end
            if (bus.PSEL !== onehot) proto_ok = 1'b0;
            if (bus.PENABLE !== (hit && c >= 2)) proto_ok = 1'b0;
            if (hit && (bus.PADDR !== addr || bus.PWDATA !== wdata || bus.PWRITE !== wr))
                proto_ok = 1'b0;
            drive_slaves(hit, idx, (c >= 2) && ((c - 1) > waits), sdata);
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(got_err), 32'(exp_err));
        check({tag, " rdata"}, got_rdata, exp_rdata);
        check({tag, " ready_at_rsp"}, 32'(got_ready), 32'd1);
        check({tag, " bus_phases"}, 32'(proto_ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        bit          seen;

        vecs[0] = '{1'b1, 32'h1000_0000, 32'h0000_00A5, 0,  32'hDEAD_BEEF, 1'b0, 32'h0,         3};
        vecs[1] = '{1'b0, 32'h1000_1004, 32'h0,         3,  32'h0000_005A, 1'b0, 32'h0000_005A, 6};
        vecs[2] = '{1'b0, 32'h2000_0000, 32'h0,         0,  32'h1111_1111, 1'b1, 32'h0,         2};
        vecs[3] = '{1'b0, 32'h1000_5000, 32'h0,         0,  32'h2222_2222, 1'b1, 32'h0,         2};
        vecs[4] = '{1'b0, 32'h1000_2000, 32'h0,         16, 32'h3333_3333, 1'b1, 32'h0,         18};
        vecs[5] = '{1'b0, 32'h1000_3FFC, 32'h0,         15, 32'h1234_5678, 1'b0, 32'h1234_5678, 18};
        vecs[6] = '{1'b1, 32'h1000_4000, 32'hCAFE_0001, 0,  32'h0,         1'b1, 32'h0,         2};
        vecs[7] = '{1'b1, 32'h1000_2ABC, 32'hCAFE_0002, 1,  32'h4444_4444, 1'b0, 32'h0,         4};
        vecs[8] = '{1'b0, 32'h1001_0000, 32'h0,         0,  32'h5555_5555, 1'b1, 32'h0,         2};
        vecs[9] = '{1'b0, 32'h1000_3000, 32'h0,         0,  32'h8765_4321, 1'b0, 32'h8765_4321, 3};

        PRESET        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PREADY_S  = '0;
        bus.PRDATA_S  = '0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("reset PSEL", 32'(bus.PSEL), 32'd0);
        check("reset PENABLE", 32'(bus.PENABLE), 32'd0);
        check("reset PWRITE", 32'(bus.PWRITE), 32'd0);
        check("reset PADDR", bus.PADDR, 32'd0);
        check("reset PWDATA", bus.PWDATA, 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                 vecs[i].sdata, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);
        end

        for (int n = 0; n < 40; n++) begin
            logic        wr;
            logic [31:0] addr;
            logic [15:0] hi;
            int          waits;
            logic [31:0] sdata;
            wr    = 1'($urandom);
            hi    = ($urandom_range(0, 5) == 0) ? 16'h2000 : 16'h1000;
            addr  = {hi, 4'($urandom_range(0, 7)), 12'($urandom)};
            waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 4));
            sdata = $urandom;
            model(wr, addr, waits, sdata, e_err, e_rdata, e_lat);
            xfer($sformatf("rnd%0d", n), wr, addr, $urandom, waits, sdata, e_err, e_rdata, e_lat);
        end

        // Reset in the middle of an ACCESS wait.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h1000_1000;
        drive_slaves(1'b1, 1, 1'b0, 32'h0);
        repeat (3) begin
            @(negedge PCLK);
            bus.req_valid = 1'b0;
            drive_slaves(1'b1, 1, 1'b0, 32'h0);
        end
        check("midreset in ACCESS", 32'(bus.PENABLE), 32'd1);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("midreset PSEL", 32'(bus.PSEL), 32'd0);
        check("midreset PENABLE", 32'(bus.PENABLE), 32'd0);
        PRESET = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge PCLK);
            drive_slaves(1'b1, 1, 1'b1, 32'h0);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("midreset no rsp", 32'(seen), 32'd0);
        check("midreset req_ready", 32'(bus.req_ready), 32'd1);

        // Back-to-back writes to slave 0 with req_valid held throughout.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h1000_0010;
        bus.req_wdata = 32'h1111_1111;
        drive_slaves(1'b1, 0, 1'b1, 32'h0);
        @(negedge PCLK);
        bus.req_addr  = 32'h1000_0020;
        bus.req_wdata = 32'h2222_2222;
        check("b2b setup1 PADDR", bus.PADDR, 32'h1000_0010);
        @(negedge PCLK);
        check("b2b access1 PWDATA", bus.PWDATA, 32'h1111_1111);
        @(negedge PCLK);
        check("b2b rsp1 valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b rsp1 ready", 32'(bus.req_ready), 32'd1);
        check("b2b rsp1 PADDR held", bus.PADDR, 32'h1000_0010);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        check("b2b rsp1 one cycle", 32'(bus.rsp_valid), 32'd0);
        check("b2b setup2 PSEL", 32'(bus.PSEL), 32'd1);
        check("b2b setup2 PENABLE", 32'(bus.PENABLE), 32'd0);
        check("b2b setup2 PADDR", bus.PADDR, 32'h1000_0020);
        check("b2b setup2 PWDATA", bus.PWDATA, 32'h2222_2222);
        @(negedge PCLK);
        check("b2b access2 PENABLE", 32'(bus.PENABLE), 32'd1);
        @(negedge PCLK);
        check("b2b rsp2 valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b rsp2 err", 32'(bus.rsp_err), 32'd0);
        check("b2b rsp2 rdata", bus.rsp_rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
